// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ctrl
// Purpose  : Alarm clock controller. It stores the alarm time, detects a
//            match on each time step and drives the ringing FSM and buzzer.
//            Define ALARM_SNOOZE_EN to build the SNOOZE state and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TONE_HZ    = 1000,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [5:0] i_alm_sec,
    input  logic [5:0] i_alm_min,
    input  logic       i_alm_load,
    input  logic       i_alarm_en,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic       o_buzz,
    output logic       o_ringing,
    output logic [1:0] o_state,
    output logic [5:0] o_alm_sec,
    output logic [5:0] o_alm_min
);

    localparam int c_HALF   = CLK_HZ / (2 * TONE_HZ);
    localparam int c_DIV_W  = $clog2(c_HALF + 1);
    localparam int c_RING_W = $clog2(RING_SEC + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_HALF - 1);
    localparam logic [c_RING_W-1:0] c_RING_LAST = c_RING_W'(RING_SEC - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RING = 2'd1;

    logic [11:0]         r_t_q;
    logic [11:0]         r_t_q2;
    logic [5:0]          r_alm_min;
    logic [5:0]          r_alm_sec;
    logic [1:0]          r_state;
    logic [c_RING_W-1:0] r_ring_cnt;
    logic [c_DIV_W-1:0]  r_div;
    logic                r_buzz;

    logic [1:0] w_state_nxt;
    logic       w_ring_clr;
    logic       w_ring_inc;
    logic       w_step;
    logic       w_match;
    logic       w_load_ok;

`ifdef ALARM_SNOOZE_EN
    localparam int c_SNZ_W = $clog2(SNOOZE_SEC + 1);
    localparam logic [c_SNZ_W-1:0] c_SNZ_LAST = c_SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [1:0] c_SNOOZE = 2'd2;

    logic [c_SNZ_W-1:0] r_snz_cnt;
    logic               w_snz_clr;
    logic               w_snz_inc;
`else
    logic w_unused_snooze;
    assign w_unused_snooze = i_snooze;
`endif

    // Both time registers reset to zero, so no step (hence no match) is
    // seen on the first cycle after reset release.
    assign w_step    = (r_t_q != r_t_q2);
    assign w_match   = w_step && (r_t_q == {r_alm_min, r_alm_sec}) && i_alarm_en;
    assign w_load_ok = i_alm_load && (i_alm_min <= 6'd59) && (i_alm_sec <= 6'd59);

    always_comb begin
        w_state_nxt = r_state;
        w_ring_clr  = 1'b0;
        w_ring_inc  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        w_snz_clr   = 1'b0;
        w_snz_inc   = 1'b0;
`endif
        if (!i_alarm_en) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_match) begin
                        w_state_nxt = c_RING;
                        w_ring_clr  = 1'b1;
                    end
                end
                c_RING: begin
                    if (i_stop) begin
                        w_state_nxt = c_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (i_snooze) begin
                        w_state_nxt = c_SNOOZE;
                        w_snz_clr   = 1'b1;
`endif
                    end else if (w_step) begin
                        if (r_ring_cnt == c_RING_LAST) w_state_nxt = c_IDLE;
                        else                           w_ring_inc  = 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                c_SNOOZE: begin
                    if (i_stop) begin
                        w_state_nxt = c_IDLE;
                    end else if (w_step) begin
                        if (r_snz_cnt == c_SNZ_LAST) begin
                            w_state_nxt = c_RING;
                            w_ring_clr  = 1'b1;
                        end else begin
                            w_snz_inc = 1'b1;
                        end
                    end
                end
`endif
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t_q      <= '0;
            r_t_q2     <= '0;
            r_alm_min  <= '0;
            r_alm_sec  <= '0;
            r_state    <= c_IDLE;
            r_ring_cnt <= '0;
        end else begin
            r_t_q   <= {i_min, i_sec};
            r_t_q2  <= r_t_q;
            r_state <= w_state_nxt;
            if (w_load_ok) begin
                r_alm_min <= i_alm_min;
                r_alm_sec <= i_alm_sec;
            end
            if (w_ring_clr)      r_ring_cnt <= '0;
            else if (w_ring_inc) r_ring_cnt <= r_ring_cnt + c_RING_W'(1);
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk) begin
        if (rst || w_snz_clr) r_snz_cnt <= '0;
        else if (w_snz_inc)   r_snz_cnt <= r_snz_cnt + c_SNZ_W'(1);
    end
`endif

    // Keyed on the next state so the buzzer is silent in the very cycle
    // RING is left, and the divider restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != c_RING) || (r_state != c_RING)) begin
            r_div  <= '0;
            r_buzz <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_buzz <= ~r_buzz;
        end else begin
            r_div  <= r_div + c_DIV_W'(1);
        end
    end

    assign o_buzz    = r_buzz;
    assign o_ringing = (r_state == c_RING);
    assign o_state   = r_state;
    assign o_alm_min = r_alm_min;
    assign o_alm_sec = r_alm_sec;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ctrl
// Purpose  : Directed and random stimulus for alarm_ctrl against a
//            behavioural model; honours ALARM_SNOOZE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

    localparam int CLK_HZ     = 1000;
    localparam int TONE_HZ    = 100;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 2;
    localparam int HALF       = CLK_HZ / (2 * TONE_HZ);
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sec = '0, min = '0, alm_sec = '0, alm_min = '0;
    logic       alm_load = 1'b0, alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic       buzz, ringing;
    logic [1:0] state;
    logic [5:0] o_alm_sec, o_alm_min;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle / 1 ring / 2 snooze; times as seconds-of-hour.
    int m_mode, m_tq, m_tq2, m_alm_min, m_alm_sec;
    int m_ring_steps, m_snz_steps, m_ring_cycles;

    alarm_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .TONE_HZ   (TONE_HZ),
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sec     (sec),
        .i_min     (min),
        .i_alm_sec (alm_sec),
        .i_alm_min (alm_min),
        .i_alm_load(alm_load),
        .i_alarm_en(alarm_en),
        .i_stop    (stop),
        .i_snooze  (snooze),
        .o_buzz    (buzz),
        .o_ringing (ringing),
        .o_state   (state),
        .o_alm_sec (o_alm_sec),
        .o_alm_min (o_alm_min)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nm;
        bit  step, match;
        if (rst) begin
            m_mode = 0; m_tq = 0; m_tq2 = 0; m_alm_min = 0; m_alm_sec = 0;
            m_ring_steps = 0; m_snz_steps = 0; m_ring_cycles = 0;
            return;
        end
        step  = (m_tq != m_tq2);
        match = step && (m_tq == m_alm_min * 60 + m_alm_sec) && alarm_en;
        nm    = m_mode;
        if (!alarm_en) nm = 0;
        else if (m_mode == 0) begin
            if (match) begin nm = 1; m_ring_steps = 0; end
        end else if (m_mode == 1) begin
            if (stop) nm = 0;
            else if (snooze && SNZ) begin nm = 2; m_snz_steps = 0; end
            else if (step) begin
                m_ring_steps++;
                if (m_ring_steps >= RING_SEC) nm = 0;
            end
        end else begin
            if (stop) nm = 0;
            else if (step) begin
                m_snz_steps++;
                if (m_snz_steps >= SNOOZE_SEC) begin nm = 1; m_ring_steps = 0; end
            end
        end
        m_ring_cycles = (nm == 1 && m_mode == 1) ? m_ring_cycles + 1 : 0;
        m_mode = nm;
        if (alm_load && alm_min <= 59 && alm_sec <= 59) begin
            m_alm_min = alm_min;
            m_alm_sec = alm_sec;
        end
        m_tq2 = m_tq;
        m_tq  = min * 60 + sec;
    endtask

    task automatic compare_all();
        check_val("state",   state,   m_mode);
        check_val("ringing", ringing, m_mode == 1);
        check_val("buzz",    buzz,    (m_mode == 1) ? (m_ring_cycles / HALF) % 2 : 0);
        check_val("alm_min", o_alm_min, m_alm_min);
        check_val("alm_sec", o_alm_sec, m_alm_sec);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_time(input int m, input int s, input int n);
        min = 6'(m);
        sec = 6'(s);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic trigger();
        set_time(1, 4, 2);
        set_time(1, 5, 2);
    endtask

    initial begin
        tick();
        tick();
        check_val("rst_state", state, 0);
        check_val("rst_buzz", buzz, 0);
        check_val("rst_alm", {o_alm_min, o_alm_sec}, 0);
        rst = 1'b0;

        // load 01:05 and ring on the second edge after the time change
        alm_min = 6'd1; alm_sec = 6'd5; alm_load = 1'b1; tick();
        alm_load = 1'b0; alarm_en = 1'b1;
        set_time(1, 4, 2);
        sec = 6'd5; tick();
        check_val("ring_edge1", ringing, 0);
        tick();
        check_val("ring_edge2", ringing, 1);
        for (int k = 0; k < 4; k++) tick();
        check_val("buzz_pre", buzz, 0);
        tick();
        check_val("buzz_toggle", buzz, 1);

        // three time steps end the ring
        set_time(1, 6, 2); set_time(1, 7, 2); set_time(1, 8, 2);
        check_val("ring_timeout", state, 0);
        check_val("timeout_buzz", buzz, 0);

        // stop and snooze together: stop wins; then 01:05 held stays idle
        trigger();
        stop = 1'b1; snooze = 1'b1; tick();
        stop = 1'b0; snooze = 1'b0;
        check_val("stop_wins", state, 0);
        for (int k = 0; k < 6; k++) tick();
        check_val("held_no_retrig", state, 0);

        // snooze then two steps back to ring
        trigger();
        snooze = 1'b1; tick(); snooze = 1'b0;
        check_val("snooze_state", state, SNZ ? 2 : 1);
        set_time(1, 6, 2); set_time(1, 7, 2);
        check_val("snooze_back", state, 1);
        stop = 1'b1; tick(); stop = 1'b0;

        // out-of-range load ignored; enable drop during ring
        alm_min = 6'd60; alm_sec = 6'd10; alm_load = 1'b1; tick(); alm_load = 1'b0;
        check_val("bad_load", {o_alm_min, o_alm_sec}, {6'd1, 6'd5});
        trigger();
        alarm_en = 1'b0; tick();
        check_val("en_drop", state, 0);
        alarm_en = 1'b1;

        // reset mid-ring
        trigger();
        tick(); tick();
        rst = 1'b1; tick();
        check_val("rst_ring", {buzz, ringing, state, o_alm_min, o_alm_sec}, 0);
        rst = 1'b0; tick();

        // random phase
        alm_min = 6'd2; alm_sec = 6'd30; alm_load = 1'b1; tick(); alm_load = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                if (sec == 6'd59) begin
                    sec = 6'd0;
                    min = (min == 6'd59) ? 6'd0 : min + 6'd1;
                end else begin
                    sec = sec + 6'd1;
                end
            end else if (r < 6) begin
                min = 6'(m_alm_min);
                sec = 6'(m_alm_sec);
            end else if (r == 6) begin
                min = 6'($urandom_range(0, 59));
                sec = 6'($urandom_range(0, 59));
            end
            stop     = ($urandom_range(0, 15) == 0);
            snooze   = ($urandom_range(0, 5) == 0);
            alm_load = ($urandom_range(0, 40) == 0);
            if (alm_load) begin
                alm_min = 6'($urandom_range(0, 63));
                alm_sec = 6'($urandom_range(0, 63));
            end
            alarm_en = ($urandom_range(0, 40) != 0);
            rst      = ($urandom_range(0, 150) == 0);
            tick();
            stop = 1'b0; snooze = 1'b0; alm_load = 1'b0; rst = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
